// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the button controller and the character block.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_RELEASE = 2'd2
  } jump_state_e;

  localparam int CHARGE_MAX_DEF = 63;

endpackage

// File: rtl/btn_ctrl_if.sv
// Button controller bundle: raw buttons and game tick in, debounced levels, strobes,
// jump charge and debug hold counters out.
interface btn_ctrl_if #(
  parameter int CNT_WIDTH    = 20,
  parameter int CHARGE_WIDTH = 8
) ();

  logic                    tick;
  logic                    left_btn;
  logic                    right_btn;
  logic                    jump_btn;
  logic                    left_lvl;
  logic                    right_lvl;
  logic                    jump_lvl;
  logic                    left_pulse;
  logic                    right_pulse;
  logic                    jump_pulse;
  logic                    jump_release;
  logic [CHARGE_WIDTH-1:0] jump_charge;
  logic [CNT_WIDTH-1:0]    left_cnt;
  logic [CNT_WIDTH-1:0]    right_cnt;
  logic [CNT_WIDTH-1:0]    jump_cnt;

  modport master (
    input  tick, left_btn, right_btn, jump_btn,
    output left_lvl, right_lvl, jump_lvl,
    output left_pulse, right_pulse, jump_pulse,
    output jump_release, jump_charge,
    output left_cnt, right_cnt, jump_cnt
  );

  modport slave (
    output tick, left_btn, right_btn, jump_btn,
    input  left_lvl, right_lvl, jump_lvl,
    input  left_pulse, right_pulse, jump_pulse,
    input  jump_release, jump_charge,
    input  left_cnt, right_cnt, jump_cnt
  );

endinterface

// File: rtl/btn_filter.sv
// One button channel: 2-flop synchronizer followed by a stable-count debounce filter.
// After reset the channel must see a debounced release before it can report a press.
module btn_filter #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn,
  output logic lvl
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          armed_r;
  logic          stable_r;

  // Synchronize, arm on a debounced low, then debounce level changes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      armed_r  <= 1'b0;
      stable_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (!armed_r) begin
        if (sync2_r) begin
          cnt_r <= {CW{1'b0}};
        end else if (cnt_r == DB_LAST) begin
          cnt_r   <= {CW{1'b0}};
          armed_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
      end else if (sync2_r != stable_r) begin
        if (cnt_r == DB_LAST) begin
          cnt_r    <= {CW{1'b0}};
          stable_r <= ~stable_r;
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign lvl = stable_r;

endmodule

// File: rtl/btn_ctrl.sv
// Button controller: three debounced channels, jump-charge FSM and optional hold counters.
// Define BTN_DEBUG_CNT_EN to build the left/right/jump debug hold counters.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int CNT_WIDTH    = 20,
  parameter int CHARGE_WIDTH = 8,
  parameter int CHARGE_MAX   = CHARGE_MAX_DEF
) (
  input logic        sys_clk,
  input logic        sys_rst_n,
  btn_ctrl_if.master bus
);

  localparam logic [CHARGE_WIDTH-1:0] CHARGE_SAT = CHARGE_WIDTH'(CHARGE_MAX);

  logic [2:0]              raw_s;
  logic [2:0]              lvl_s;
  logic [2:0]              lvl_d_r;
  logic [2:0]              pulse_r;
  logic                    jump_rise_s;
  jump_state_e             state_r;
  logic                    release_r;
  logic [CHARGE_WIDTH-1:0] charge_r;

  // Channel order: [0] left, [1] right, [2] jump
  assign raw_s = {bus.jump_btn, bus.right_btn, bus.left_btn};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    btn_filter #(.DB_CYCLES(DB_CYCLES)) u_filter (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .btn       (raw_s[i]),
      .lvl       (lvl_s[i])
    );
  end

  assign jump_rise_s = lvl_s[2] & ~lvl_d_r[2];

  // Rising-edge strobes, one cycle after each level goes high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lvl_d_r <= 3'b000;
      pulse_r <= 3'b000;
    end else begin
      lvl_d_r <= lvl_s;
      pulse_r <= lvl_s & ~lvl_d_r;
    end
  end

  // Jump FSM; charge clears on the same edge that raises jump_pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      release_r <= 1'b0;
      charge_r  <= {CHARGE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          release_r <= 1'b0;
          if (jump_rise_s) begin
            state_r  <= ST_CHARGE;
            charge_r <= {CHARGE_WIDTH{1'b0}};
          end
        end
        ST_CHARGE: begin
          if (!lvl_s[2]) begin
            state_r   <= ST_RELEASE;
            release_r <= 1'b1;
          end else if (bus.tick && (charge_r < CHARGE_SAT)) begin
            charge_r <= charge_r + CHARGE_WIDTH'(1'b1);
          end
        end
        ST_RELEASE: begin
          state_r   <= ST_IDLE;
          release_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          release_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.left_lvl     = lvl_s[0];
  assign bus.right_lvl    = lvl_s[1];
  assign bus.jump_lvl     = lvl_s[2];
  assign bus.left_pulse   = pulse_r[0];
  assign bus.right_pulse  = pulse_r[1];
  assign bus.jump_pulse   = pulse_r[2];
  assign bus.jump_release = release_r;
  assign bus.jump_charge  = charge_r;

`ifdef BTN_DEBUG_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_r [3];

  // Hold counters advance on each tick while the level is high, wrapping freely
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.tick && lvl_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1'b1);
        end
      end
    end
  end

  assign bus.left_cnt  = cnt_r[0];
  assign bus.right_cnt = cnt_r[1];
  assign bus.jump_cnt  = cnt_r[2];
`else
  assign bus.left_cnt  = {CNT_WIDTH{1'b0}};
  assign bus.right_cnt = {CNT_WIDTH{1'b0}};
  assign bus.jump_cnt  = {CNT_WIDTH{1'b0}};
`endif

endmodule
